wallace_tree_multiplier: RTL and testbench
==========================================

Name: wallace_tree_multiplier

Overview:
- Unsigned 4x4-bit multiplier built as a Wallace tree: partial-product generation, carry-save reduction with half/full adders, and a final carry-propagate adder.
- The 8-bit product is registered. The block is a leaf arithmetic unit used wherever a small, fixed-latency unsigned multiply is needed in the clocked datapath.

Parameters:
- None. Operand width is fixed at 4 bits and product width at 8 bits; no generic width.

Ports:
- clk  input  1  rising-edge clock; the single clock of the block
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  qualifies A/B on this clock edge
- A  input  4  unsigned multiplicand
- B  input  4  unsigned multiplier
- Product  output  8  registered unsigned product A*B
- out_valid  output  1  high for one cycle when Product holds a new result

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. While rst_n=0, Product=8'h00 and out_valid=0, immediately and regardless of clk.
- Partial products: pp[i][j] = A[j] & B[i], with weight 2^(i+j), for i,j in 0..3 (16 bits across columns 0..6).
- Reduction: Wallace scheme.
  - In each stage, every group of 3 bits in a column goes to a full adder and every leftover pair goes to a half adder, where the Wallace rule calls for it.
  - Sum stays in the column; carry moves to column+1.
  - Repeat until each column has at most 2 bits. For 4x4 this takes 2 reduction stages.
- FA/HA are separate leaf modules instantiated structurally. Behavioural "*" is not allowed anywhere in the block.
- Final adder: ripple-carry over the two remaining rows. Carry out of column 6 becomes Product[7]. No overflow is possible: 15*15 = 225 < 256.
- Timing: the tree and adder are purely combinational from A/B.
  - The result registers on the rising clk edge when in_valid=1. Latency is 1 cycle.
  - out_valid <= in_valid every cycle.
  - When in_valid=0, Product holds its last value and out_valid drops to 0.
- Throughput: one new operation per cycle; back-to-back in_valid is fully supported. No backpressure and no ready signal.
- Reset mid-operation: any in-flight result is discarded; Product=0 and out_valid=0 until the first in_valid edge after rst_n deasserts.
- Zero operand: Product=0 for any A when B=0, and vice versa.
- Result must equal A*B bit-exactly for all 256 operand pairs.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with prior Product=225 -> Product=0x00 and out_valid=0 immediately. After release, both stay 0 until in_valid is seen.
- Directed vectors, one per cycle with in_valid=1; each result appears one cycle later with out_valid=1:
  - 1*0 -> 0
  - 11*4 -> 44 (0x2C)
  - 13*7 -> 91 (0x5B)
  - 9*7 -> 63 (0x3F)
  - 15*15 -> 225 (0xE1)
  - 5*3 -> 15 (0x0F)
- Hold: apply 13*7 with in_valid=1, then change A/B to 15*15 with in_valid=0 -> Product stays 91 and out_valid=0 on the following cycle.
- Back-to-back: stream 11*4, 15*15, 0*15 on consecutive cycles -> outputs 44, 225, 0 on consecutive cycles, with out_valid continuously high.
- Exhaustive: all 256 A/B pairs with in_valid=1 -> Product == A*B on each following cycle, checked against a reference model.
- Reset mid-stream: drop rst_n during a stream of 9*7 -> no stale 63 appears after release. The first output equals the first post-reset operand pair.

Source files
------------

// File: rtl/wallace_tree_multiplier.sv
// Unsigned 4x4 Wallace-tree multiplier: two carry-save stages, ripple final adder, registered product.
// One-cycle latency, one operation per cycle, no backpressure; Product holds when in_valid is low.
module wallace_tree_multiplier (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [7:0] Product,
   output logic       out_valid
);

   // pp[i][j] = A[j] & B[i], weight 2^(i+j)
   logic [3:0] pp [4];
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pp[i] = A & {4{B[i]}};
      end
   end

   // Stage 1: a full adder on each 3-bit group in columns 2..4; pp[3][0] and columns 5/6 pass through
   logic s1_2, c1_3, s1_3, c1_4, s1_4, c1_5;
   wallace_fa u_fa1_2 (.a_i(pp[0][2]), .b_i(pp[1][1]), .ci_i(pp[2][0]), .sum_o(s1_2), .co_o(c1_3));
   wallace_fa u_fa1_3 (.a_i(pp[0][3]), .b_i(pp[1][2]), .ci_i(pp[2][1]), .sum_o(s1_3), .co_o(c1_4));
   wallace_fa u_fa1_4 (.a_i(pp[1][3]), .b_i(pp[2][2]), .ci_i(pp[3][1]), .sum_o(s1_4), .co_o(c1_5));

   // Stage 2: the half adder in column 4 makes room for the column-3 carry, so nothing spills past column 6
   logic s2_3, c2_4, s2_4, c2_5, s2_5, c2_6;
   wallace_fa u_fa2_3 (.a_i(s1_3),     .b_i(pp[3][0]), .ci_i(c1_3), .sum_o(s2_3), .co_o(c2_4));
   wallace_ha u_ha2_4 (.a_i(s1_4),     .b_i(c1_4),                  .sum_o(s2_4), .co_o(c2_5));
   wallace_fa u_fa2_5 (.a_i(pp[2][3]), .b_i(pp[3][2]), .ci_i(c1_5), .sum_o(s2_5), .co_o(c2_6));

   logic [6:0] row_a;
   logic [6:0] row_b;
   logic [6:0] sum;
   logic [7:0] carry;

   assign row_a    = {pp[3][3], s2_5, s2_4, s2_3, s1_2, pp[0][1], pp[0][0]};
   assign row_b    = {c2_6, c2_5, c2_4, 1'b0, 1'b0, pp[1][0], 1'b0};
   assign carry[0] = 1'b0;

   for (genvar k = 0; k < 7; k++) begin : g_cpa
      wallace_fa u_fa (
         .a_i   (row_a[k]),
         .b_i   (row_b[k]),
         .ci_i  (carry[k]),
         .sum_o (sum[k]),
         .co_o  (carry[k+1])
      );
   end

   logic [7:0] product_d;
   logic [7:0] product_q;
   logic       out_valid_q;

   assign product_d = {carry[7], sum};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product_q   <= 8'h00;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            product_q <= product_d;
         end
      end
   end

   assign Product   = product_q;
   assign out_valid = out_valid_q;

endmodule

module wallace_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic sum_o,
   output logic co_o
);
   assign sum_o = a_i ^ b_i ^ ci_i;
   assign co_o  = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module wallace_ha (
   input  logic a_i,
   input  logic b_i,
   output logic sum_o,
   output logic co_o
);
   assign sum_o = a_i ^ b_i;
   assign co_o  = a_i & b_i;
endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// Scoreboard bench for wallace_tree_multiplier: expected {out_valid, Product} queued per driven cycle.
module tb_wallace_tree_multiplier;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [7:0] prod;
   logic       out_vld;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q [$];
   logic [7:0] model_prod;
   logic [8:0] exp_e;

   wallace_tree_multiplier dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (in_a),
      .B         (in_b),
      .Product   (prod),
      .out_valid (out_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [8:0] obs, input logic [8:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got vld=%0b prod=%0d, want vld=%0b prod=%0d",
                  tag, obs[8], obs[7:0], expv[8], expv[7:0]);
      end
   endtask

   // Inputs change on the falling edge; the expectation for the following rising edge is queued.
   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic v, input logic [7:0] expp);
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_valid = v;
      if (v) model_prod = expp;
      exp_q.push_back({v, model_prod});
   endtask

   always @(posedge clk) begin
      #2;
      if (rst_n) begin
         if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check_eq("out", {out_vld, prod}, exp_e);
         end else if (out_vld) begin
            check_eq("spurious_out", {out_vld, prod}, 9'h000);
         end
      end
   end

   int dir_a [6] = '{1, 11, 13, 9, 15, 5};
   int dir_b [6] = '{0, 4, 7, 7, 15, 3};
   int dir_p [6] = '{0, 44, 91, 63, 225, 15};

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_a       = 4'd0;
      in_b       = 4'd0;
      model_prod = 8'h00;

      #12;
      check_eq("reset_state", {out_vld, prod}, 9'h000);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, back to back
      for (int k = 0; k < 6; k++) begin
         drive(dir_a[k][3:0], dir_b[k][3:0], 1'b1, dir_p[k][7:0]);
      end
      drive(4'd0, 4'd0, 1'b0, 8'h00);

      // Hold: operands change while in_valid is low
      drive(4'd13, 4'd7, 1'b1, 8'd91);
      drive(4'd15, 4'd15, 1'b0, 8'h00);
      drive(4'd15, 4'd15, 1'b0, 8'h00);

      // Back-to-back stream
      drive(4'd11, 4'd4, 1'b1, 8'd44);
      drive(4'd15, 4'd15, 1'b1, 8'd225);
      drive(4'd0, 4'd15, 1'b1, 8'd0);
      drive(4'd0, 4'd0, 1'b0, 8'h00);

      // Exhaustive against the reference multiply
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            drive(a[3:0], b[3:0], 1'b1, 8'(a * b));
         end
      end

      // Asynchronous reset mid-cycle with 225 in the register
      drive(4'd15, 4'd15, 1'b1, 8'd225);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      model_prod = 8'h00;
      #1;
      check_eq("rst_async", {out_vld, prod}, 9'h000);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'd15, 4'd15, 1'b0, 8'h00);
      drive(4'd15, 4'd15, 1'b0, 8'h00);

      // Reset dropped during a 9*7 stream
      drive(4'd9, 4'd7, 1'b1, 8'd63);
      drive(4'd9, 4'd7, 1'b1, 8'd63);
      drive(4'd9, 4'd7, 1'b1, 8'd63);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      model_prod = 8'h00;
      #1;
      check_eq("rst_mid", {out_vld, prod}, 9'h000);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'd9, 4'd7, 1'b0, 8'h00);
      drive(4'd6, 4'd5, 1'b1, 8'd30);
      drive(4'd0, 4'd0, 1'b0, 8'h00);

      repeat (3) @(posedge clk);
      #3;
      check_eq("drain", 9'(exp_q.size()), 9'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
